// File: rtl/serial_compare_ctrl.sv
// Byte-serial LT/EQ/GT compare sequencer: walks operands MSB-first through one
// 8-bit slice, stopping at the first unequal byte, with a start/busy/done handshake.
module serial_compare_ctrl #(
  parameter int NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic                   i_signed_mode,
  input  logic [8*NUM_BYTES-1:0] i_op_a,
  input  logic [8*NUM_BYTES-1:0] i_op_b,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_lt,
  output logic                   o_eq,
  output logic                   o_gt
);

  localparam int W     = 8 * NUM_BYTES;
  localparam int IDX_W = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_a, r_b, w_a_nxt, w_b_nxt;
  logic             r_signed, w_signed_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_lt, r_eq, r_gt;
  logic             w_lt_nxt, w_eq_nxt, w_gt_nxt;
  logic             r_busy, r_done;

  logic [7:0]       w_a_byte, w_b_byte, w_a_cmp, w_b_cmp;
  logic             w_flip, w_slice_eq, w_slice_lt;

  // Only the top byte carries the sign; flipping its MSB maps two's complement onto unsigned order.
  always_comb begin
    w_a_byte   = r_a[{r_idx, 3'b000} +: 8];
    w_b_byte   = r_b[{r_idx, 3'b000} +: 8];
    w_flip     = r_signed & (r_idx == IDX_TOP);
    w_a_cmp    = {w_a_byte[7] ^ w_flip, w_a_byte[6:0]};
    w_b_cmp    = {w_b_byte[7] ^ w_flip, w_b_byte[6:0]};
    w_slice_eq = (w_a_cmp == w_b_cmp);
    w_slice_lt = (w_a_cmp < w_b_cmp);
  end

  // Next-state and next-datapath logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_signed_nxt = r_signed;
    w_idx_nxt    = r_idx;
    w_lt_nxt     = r_lt;
    w_eq_nxt     = r_eq;
    w_gt_nxt     = r_gt;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt  = ST_CMP;
          w_a_nxt      = i_op_a;
          w_b_nxt      = i_op_b;
          w_signed_nxt = i_signed_mode;
          w_idx_nxt    = IDX_TOP;
          w_lt_nxt     = 1'b0;
          w_eq_nxt     = 1'b0;
          w_gt_nxt     = 1'b0;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_CMP: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_slice_eq) begin
          w_lt_nxt    = w_slice_lt;
          w_gt_nxt    = ~w_slice_lt;
          w_state_nxt = ST_DONE;
        end else if (r_idx == {IDX_W{1'b0}}) begin
          w_eq_nxt    = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_idx_nxt   = r_idx - IDX_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, operand and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a      <= {W{1'b0}};
      r_b      <= {W{1'b0}};
      r_signed <= 1'b0;
      r_idx    <= {IDX_W{1'b0}};
      r_lt     <= 1'b0;
      r_eq     <= 1'b0;
      r_gt     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_signed <= w_signed_nxt;
      r_idx    <= w_idx_nxt;
      r_lt     <= w_lt_nxt;
      r_eq     <= w_eq_nxt;
      r_gt     <= w_gt_nxt;
      r_busy   <= (w_state_nxt == ST_CMP);
      r_done   <= (w_state_nxt == ST_DONE);
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_lt   = r_lt;
  assign o_eq   = r_eq;
  assign o_gt   = r_gt;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed self-checking bench for serial_compare_ctrl with NUM_BYTES=4.
module tb_serial_compare_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start, abort, signed_mode;
  logic [31:0] op_a, op_b;
  logic        busy, done, lt, eq, gt;

  int checks;
  int failures;

  serial_compare_ctrl #(.NUM_BYTES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start),
    .i_abort       (abort),
    .i_signed_mode (signed_mode),
    .i_op_a        (op_a),
    .i_op_b        (op_b),
    .o_busy        (busy),
    .o_done        (done),
    .o_lt          (lt),
    .o_eq          (eq),
    .o_gt          (gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a compare at edge 0, scrambles inputs afterwards, returns done cycle (0 = timeout).
  task automatic run_cmp(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output int done_cyc, output int busy_cnt);
    op_a = a; op_b = b; signed_mode = sgn; start = 1'b1;
    step();
    start = 1'b0; op_a = ~a; op_b = ~b; signed_mode = ~sgn;
    done_cyc = 0;
    busy_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; signed_mode = 1'b0;
    op_a = 32'h0; op_b = 32'h0;
    step(); step();
    checks++;
    if ({busy, done, lt, eq, gt} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_hold: got %b expected 00000", {busy, done, lt, eq, gt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(); step(); step();
    checks++;
    if ({busy, done, lt, eq, gt} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_release: got %b expected 00000", {busy, done, lt, eq, gt});
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic        vs [7];
    logic [2:0]  vr [7];
    int          vd [7];
    int          dc, bc;
    va[0] = 32'h12345678; vb[0] = 32'h12345679; vs[0] = 1'b0; vr[0] = 3'b100; vd[0] = 5;
    va[1] = 32'h80000000; vb[1] = 32'h00000001; vs[1] = 1'b0; vr[1] = 3'b001; vd[1] = 2;
    va[2] = 32'h80000000; vb[2] = 32'h00000001; vs[2] = 1'b1; vr[2] = 3'b100; vd[2] = 2;
    va[3] = 32'h000000FF; vb[3] = 32'h00000001; vs[3] = 1'b1; vr[3] = 3'b001; vd[3] = 5;
    va[4] = 32'hFFFFFFFF; vb[4] = 32'h00000000; vs[4] = 1'b1; vr[4] = 3'b100; vd[4] = 2;
    va[5] = 32'h12005678; vb[5] = 32'h12FF0000; vs[5] = 1'b0; vr[5] = 3'b100; vd[5] = 3;
    va[6] = 32'h7F000000; vb[6] = 32'h80000000; vs[6] = 1'b1; vr[6] = 3'b001; vd[6] = 2;
    for (int i = 0; i < 7; i++) begin
      run_cmp(va[i], vb[i], vs[i], dc, bc);
      checks++;
      if (dc !== vd[i]) begin
        failures++;
        $display("FAIL vec%0d_done_cycle: got %0d expected %0d", i, dc, vd[i]);
      end
      checks++;
      if (bc !== vd[i] - 1) begin
        failures++;
        $display("FAIL vec%0d_busy_cycles: got %0d expected %0d", i, bc, vd[i] - 1);
      end
      checks++;
      if ({lt, eq, gt} !== vr[i]) begin
        failures++;
        $display("FAIL vec%0d_result: got %b expected %b", i, {lt, eq, gt}, vr[i]);
      end
      step();
      checks++;
      if ({busy, done, lt, eq, gt} !== {2'b00, vr[i]}) begin
        failures++;
        $display("FAIL vec%0d_after_done: got %b expected %b", i, {busy, done, lt, eq, gt}, {2'b00, vr[i]});
      end
    end
  endtask

  task automatic test_equal();
    int dc, bc;
    for (int m = 0; m < 2; m++) begin
      run_cmp(32'hDEADBEEF, 32'hDEADBEEF, m[0], dc, bc);
      checks++;
      if (dc !== 5 || {lt, eq, gt} !== 3'b010) begin
        failures++;
        $display("FAIL equal_mode%0d: got cycle %0d res %b expected cycle 5 res 010", m, dc, {lt, eq, gt});
      end
      op_a = 32'h1; op_b = 32'h2;
      step(); step(); step();
      checks++;
      if ({busy, done, lt, eq, gt} !== 5'b00010) begin
        failures++;
        $display("FAIL equal_hold%0d: got %b expected 00010", m, {busy, done, lt, eq, gt});
      end
    end
  endtask

  task automatic test_start_ignored();
    int dc;
    op_a = 32'h1; op_b = 32'h2; signed_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0; op_a = 32'h5; op_b = 32'h1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    dc = 0;
    for (int c = 3; c <= 20; c++) begin
      if (done) begin
        dc = c;
        break;
      end
      step();
    end
    checks++;
    if (dc !== 5 || {lt, eq, gt} !== 3'b100) begin
      failures++;
      $display("FAIL start_in_cmp: got cycle %0d res %b expected cycle 5 res 100", dc, {lt, eq, gt});
    end
    step();
  endtask

  task automatic test_abort();
    int dc, seen;
    op_a = 32'h1; op_b = 32'h2; signed_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({busy, done, lt, eq, gt} !== 5'b00000) begin
      failures++;
      $display("FAIL abort_cmp: got %b expected 00000", {busy, done, lt, eq, gt});
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (done || busy) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d active cycles expected 0", seen);
    end
    // start and abort together in IDLE: start must win
    op_a = 32'h3; op_b = 32'h1; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL start_abort_idle: got busy %b expected 1", busy);
    end
    dc = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        dc = c;
        break;
      end
      step();
    end
    checks++;
    if (dc !== 5 || {lt, eq, gt} !== 3'b001) begin
      failures++;
      $display("FAIL start_abort_result: got cycle %0d res %b expected cycle 5 res 001", dc, {lt, eq, gt});
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({busy, done, lt, eq, gt} !== 5'b00001) begin
      failures++;
      $display("FAIL abort_in_done: got %b expected 00001", {busy, done, lt, eq, gt});
    end
  endtask

  task automatic test_async_reset();
    int dc, bc;
    op_a = 32'h1; op_b = 32'h2; signed_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, lt, eq, gt} !== 5'b00000) begin
      failures++;
      $display("FAIL async_reset: got %b expected 00000", {busy, done, lt, eq, gt});
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_cmp(32'hA5A5A5A5, 32'hA5A5A5A4, 1'b0, dc, bc);
    checks++;
    if (dc !== 5 || bc !== 4 || {lt, eq, gt} !== 3'b001) begin
      failures++;
      $display("FAIL post_reset_cmp: got cycle %0d busy %0d res %b expected 5 4 001", dc, bc, {lt, eq, gt});
    end
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_vectors();
    test_equal();
    test_start_ignored();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
